// File: rtl/bignum_word_serializer_pkg.sv
// Shared definitions for the bignum word serializer.
//   DEFAULT_BITS_IN_NUM   - default width of a parallel number
//   DEFAULT_BITS_PER_WORD - default width of an emitted word
//   ser_state_e           - IDLE / STREAM state encoding
package bignum_word_serializer_pkg;

  localparam int DEFAULT_BITS_IN_NUM   = 4096;
  localparam int DEFAULT_BITS_PER_WORD = 32;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } ser_state_e;

endpackage

// File: rtl/evt_counter.sv
// Event counter that wraps from MAX_COUNT-1 back to 0.
//   clk_in    - clock, rising edge
//   rst_in    - synchronous active-high reset, loads COUNT_START
//   evt_in    - advance the count by one
//   count_out - current count
module evt_counter #(
  parameter int MAX_COUNT   = 4,
  parameter int COUNT_START = 0,
  localparam int CNT_W      = (MAX_COUNT > 1) ? $clog2(MAX_COUNT) : 1
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             evt_in,
  output logic [CNT_W-1:0] count_out
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (evt_in) begin
      if (count_q == CNT_W'(MAX_COUNT - 1)) count_d = '0;
      else                                  count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) count_q <= CNT_W'(COUNT_START);
    else        count_q <= count_d;
  end

  assign count_out = count_q;

endmodule

// File: rtl/bignum_word_serializer.sv
// Serializes a BITS_IN_NUM-wide number into NUM_WORDS words of BITS_PER_WORD,
// least significant word first, over a valid/ready stream.
//   clk_in         - clock, rising edge
//   rst_in         - synchronous active-high reset
//   data_valid_in  - load request for data_in
//   data_in        - number to serialize
//   data_ready_out - load accepted this cycle (high in IDLE)
//   word_valid_out - word_out / word_idx_out / word_last_out are valid
//   word_ready_in  - downstream accepts the current word
//   word_out       - current word (low word of the shift register)
//   word_idx_out   - index of the current word
//   word_last_out  - current word is index NUM_WORDS-1
module bignum_word_serializer
  import bignum_word_serializer_pkg::*;
#(
  parameter int  BITS_IN_NUM   = DEFAULT_BITS_IN_NUM,
  parameter int  BITS_PER_WORD = DEFAULT_BITS_PER_WORD,
  localparam int NUM_WORDS     = BITS_IN_NUM / BITS_PER_WORD,
  localparam int IDX_W         = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     data_valid_in,
  input  logic [BITS_IN_NUM-1:0]   data_in,
  output logic                     data_ready_out,
  output logic                     word_valid_out,
  input  logic                     word_ready_in,
  output logic [BITS_PER_WORD-1:0] word_out,
  output logic [IDX_W-1:0]         word_idx_out,
  output logic                     word_last_out
);

  generate
    if (BITS_IN_NUM % BITS_PER_WORD != 0) begin : g_bad_div
      $error("BITS_IN_NUM must be a multiple of BITS_PER_WORD");
    end
    if (NUM_WORDS < 2) begin : g_bad_words
      $error("NUM_WORDS must be at least 2");
    end
  endgenerate

  logic [NUM_WORDS-1:0][BITS_PER_WORD-1:0] num_q, num_d;
  ser_state_e       state_q, state_d;
  logic             data_ready_q, data_ready_d;
  logic             word_valid_q, word_valid_d;
  logic [IDX_W-1:0] idx;
  logic             load, xfer, last;

  assign load = data_valid_in & data_ready_q;
  assign xfer = word_valid_q & word_ready_in;
  // Gated by valid so an idle block never flags last, whatever the index.
  assign last = word_valid_q & (idx == IDX_W'(NUM_WORDS - 1));

  // Index restarts on every load so a number always begins at word 0.
  evt_counter #(
    .MAX_COUNT   (NUM_WORDS),
    .COUNT_START (0)
  ) u_idx_cnt (
    .clk_in    (clk_in),
    .rst_in    (rst_in | load),
    .evt_in    (xfer),
    .count_out (idx)
  );

  always_comb begin
    num_d = num_q;
    if (load)      num_d = data_in;
    else if (xfer) num_d = num_q >> BITS_PER_WORD;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (load)        state_d = ST_STREAM;
      ST_STREAM: if (xfer & last) state_d = ST_IDLE;
      default:                    state_d = ST_IDLE;
    endcase
    // Handshake outputs are registered copies of the next state.
    data_ready_d = (state_d == ST_IDLE);
    word_valid_d = (state_d == ST_STREAM);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q      <= ST_IDLE;
      data_ready_q <= 1'b1;
      word_valid_q <= 1'b0;
      num_q        <= '0;
    end else begin
      state_q      <= state_d;
      data_ready_q <= data_ready_d;
      word_valid_q <= word_valid_d;
      num_q        <= num_d;
    end
  end

  assign data_ready_out = data_ready_q;
  assign word_valid_out = word_valid_q;
  assign word_out       = num_q[0];
  assign word_idx_out   = idx;
  assign word_last_out  = last;

endmodule

// File: doc/bignum_word_serializer.md
BIGNUM_WORD_SERIALIZER -- requirements
Module: bignum_word_serializer

Interface
REQ-001 Parameter BITS_IN_NUM, default 4096, width of the parallel number accepted per load.
REQ-002 Parameter BITS_PER_WORD, default 32, width of each emitted word.
REQ-003 Derived constant NUM_WORDS = BITS_IN_NUM / BITS_PER_WORD; not overridable.
REQ-004 clk_in  input  1  single clock; all logic on its rising edge.
REQ-005 rst_in  input  1  reset; synchronous, active-high.
REQ-006 data_valid_in  input  1  load request for data_in.
REQ-007 data_in  input  BITS_IN_NUM  number to serialize; word 0 = bits [BITS_PER_WORD-1:0].
REQ-008 data_ready_out  output  1  high when a load is accepted this cycle.
REQ-009 word_valid_out  output  1  word_out, word_idx_out and word_last_out are valid.
REQ-010 word_ready_in  input  1  downstream accepts the current word.
REQ-011 word_out  output  BITS_PER_WORD  current word.
REQ-012 word_idx_out  output  $clog2(NUM_WORDS)  index of the current word, 0 = least significant.
REQ-013 word_last_out  output  1  high with the word whose index is NUM_WORDS-1.

Function
REQ-014 The block SHALL have two states: IDLE and STREAM.
REQ-015 In IDLE: data_ready_out=1, word_valid_out=0.
REQ-016 In STREAM: data_ready_out=0, word_valid_out=1.
REQ-017 A load SHALL occur when data_valid_in & data_ready_out; data_in is captured into an internal BITS_IN_NUM register; the word index is cleared to 0; the next state is STREAM.
REQ-018 The first word SHALL be valid on the cycle after the load; latency is 1 cycle.
REQ-019 A transfer SHALL occur when word_valid_out & word_ready_in; on a transfer the register shifts right by BITS_PER_WORD (zero fill) and the word index increments by 1.
REQ-020 word_out SHALL always equal the low BITS_PER_WORD bits of the register; no combinational path from word_ready_in to word_out.
REQ-021 When word_ready_in=0 in STREAM: word_out, word_idx_out and word_last_out SHALL hold stable; word_valid_out stays 1 (no retraction).
REQ-022 A transfer with word_last_out=1 SHALL return the block to IDLE next cycle, with the index wrapped to 0.
REQ-023 data_ready_out is low in STREAM; data_valid_in there SHALL be ignored, with no effect on the register or index.
REQ-024 Back-to-back numbers SHALL incur exactly one idle cycle between the last word of one number and the first word of the next.
REQ-025 Exactly NUM_WORDS transfers SHALL occur per load, in index order 0..NUM_WORDS-1, with no skipped or repeated index.
REQ-026 Outputs in IDLE: word_out SHALL be the register low word (don't-care for consumers); word_idx_out=0; word_last_out=0.

Reset
REQ-027 With rst_in high at a clock edge: state -> IDLE, word index -> 0, register -> 0, word_valid_out=0, data_ready_out=1 on the following cycle.
REQ-028 Reset mid-STREAM SHALL abandon the number with no further words emitted; the next load restarts at index 0.
REQ-029 rst_in SHALL take priority over a simultaneous load or transfer.

Structure
REQ-030 The word index SHALL be an instance of evt_counter with MAX_COUNT=NUM_WORDS and COUNT_START=0; evt_in = transfer, rst_in = rst_in | load.
REQ-031 The IDLE/STREAM enum and the default BITS_IN_NUM/BITS_PER_WORD constants SHALL live in the shared project package; the shift register and FSM stay local.
REQ-032 Elaboration SHALL fail unless BITS_IN_NUM % BITS_PER_WORD == 0 and NUM_WORDS >= 2.

Verification (bench: BITS_IN_NUM=128, BITS_PER_WORD=32)
REQ-033 Load 0x00000004_00000003_00000002_00000001 with word_ready_in=1 -> words 1,2,3,4 on 4 consecutive cycles starting the cycle after the load, indices 0..3, last only on 4.
REQ-034 Same load, word_ready_in low for 3 cycles during index 1 -> word 2 / index 1 held stable, valid held high, remaining order unchanged.
REQ-035 data_valid_in held high with a new value while streaming -> ignored; first number completes intact; second loads in the idle cycle after the last word.
REQ-036 rst_in pulsed while index 2 is presented -> word_valid_out=0 next cycle, idx=0; a fresh load 0xA..A restarts at index 0.
REQ-037 Random data_valid_in / word_ready_in over 1000 numbers -> scoreboard matches every word, one last per number, no valid retraction.
